// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Glyph table is active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_e;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_if.sv
// Frame load port between the processor output register and the scanner.
// The master presents a frame and strobes load; the slave acknowledges.
interface seg7_if #(
    parameter int DIGITS = 4
);

    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blank_mask;
    logic                load;
    logic                load_ack;

    modport master (
        output value,
        output dp_mask,
        output blank_mask,
        output load,
        input  load_ack
    );

    modport slave (
        input  value,
        input  dp_mask,
        input  blank_mask,
        input  load,
        output load_ack
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high segment pattern; a blanked digit lights nothing.
// Pin polarity is handled by the caller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = 7'h00;
        if (!blank) begin
            pattern = SEG_LUT[nibble];
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner stepped by an asynchronous slow toggle,
// with a double-buffered frame committed only when the scan wraps.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int GUARD_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    seg7_if.slave             bus,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
    localparam logic              DP_OFF  = ACTIVE_LOW;

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;

    logic load_ack_q, load_ack_d;

    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic step;
    logic wrap;

    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              cur_dp;
    logic [6:0]        cur_pat;
    logic [DIGITS-1:0] cur_onehot;

    assign step = s2_q & ~s3_q;
    // Only a step accepted in SHOW advances; the last digit's step wraps.
    assign wrap = step && (state_q == SHOW) && (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= SHOW;
            idx_q        <= LAST;
            cnt_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            load_ack_q   <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            load_ack_q   <= load_ack_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SHOW: begin
                if (step) begin
                    state_d = BLANK;
                    cnt_d   = CW'(GUARD_CYCLES - 1);
                    idx_d   = wrap ? '0 : idx_q + IW'(1);
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_d = sclk;
        s2_d = s1_q;
        s3_d = s2_q;

        load_ack_d   = bus.load;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;

        // Commit reads the old pending copy even if a load lands now.
        if (wrap && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            disp_blank_d = pend_blank_q;
            pend_valid_d = 1'b0;
        end
        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp_mask;
            pend_blank_d = bus.blank_mask;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib           = disp_val_q[{idx_q, 2'b00} +: 4];
        cur_blank         = disp_blank_q[idx_q];
        cur_dp            = disp_dp_q[idx_q] & ~cur_blank;
        cur_onehot        = '0;
        cur_onehot[idx_q] = 1'b1;
    end

    seg7_hex_decode u_dec (
        .nibble  (cur_nib),
        .blank   (cur_blank),
        .pattern (cur_pat)
    );

    // Pins change only on state transitions; idx_q already holds the new digit.
    always_comb begin
        seg_d = seg_q;
        dp_d  = dp_q;
        an_d  = an_q;
        if (state_q == SHOW && state_d == BLANK) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            an_d  = AN_OFF;
        end else if (state_q == BLANK && state_d == SHOW) begin
            seg_d = cur_pat ^ SEG_OFF;
            dp_d  = cur_dp ^ DP_OFF;
            an_d  = cur_onehot ^ AN_OFF;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign frame_done   = wrap;
    assign bus.load_ack = load_ack_q;

endmodule
